tvp_pattern_gen: RTL

Synthetic video source that emulates the TVP digitiser output (HSYNC, VSYNC, 10-bit luma) on the TVP clock domain. It drives the RX capture path in place of the TVP during bring-up, board self-test and simulation. A top-level mux selects between this block and the real TVP pins before the RX module. Raster geometry is parameterised, and the picture content comes from a small set of selectable test patterns.

---
 rtl/hp2vga_pkg.sv | 21 ++
 rtl/tvp_pattern_gen_timing.sv | 70 +++++++
 rtl/tvp_pattern_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hp2vga_pkg.sv
// Shared definitions for the video test-pattern path: pattern encodings,
// default luma levels and the ramp helper.
package hp2vga_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

  localparam logic [9:0] DEF_LVL_BLANK = 10'h000;
  localparam logic [9:0] DEF_LVL_BLACK = 10'h040;
  localparam logic [9:0] DEF_LVL_WHITE = 10'h3C0;

  // Ramp advances by 4 codes per frame and wraps naturally at 10 bits.
  function automatic logic [9:0] ramp_value(input logic [9:0] xpos, input logic [7:0] frame);
    return xpos + {frame, 2'b00};
  endfunction

endpackage

// File: rtl/tvp_pattern_gen_timing.sv
// video_timing_gen: raster h/v counters with sync, active-window decode and
// window-relative x/y coordinates. Reusable by TX-side test logic.
module video_timing_gen #(
  parameter int H_TOTAL  = 1040,
  parameter int H_SYNC   = 80,
  parameter int H_BP     = 120,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 400,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 20,
  parameter int V_ACTIVE = 368
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       hsync_act,
  output logic       vsync_act,
  output logic       active,
  output logic       origin,
  output logic       frame_end,
  output logic [9:0] x,
  output logic [9:0] y
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_START    = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_END      = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_START    = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_END      = VW'(V_SYNC + V_BP + V_ACTIVE);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          line_end;
  logic          h_act;
  logic          v_act;

  // Disabled counts as reset so the first running cycle is always h=0, v=0.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);
  assign origin    = (h_cnt == '0) && (v_cnt == '0);

  assign hsync_act = (h_cnt < H_SYNC_END);
  assign vsync_act = (v_cnt < V_SYNC_END);

  assign h_act  = (h_cnt >= H_START) && (h_cnt < H_END);
  assign v_act  = (v_cnt >= V_START) && (v_cnt < V_END);
  assign active = h_act && v_act;

  assign x = h_act ? 10'(h_cnt - H_START) : '0;
  assign y = v_act ? 10'(v_cnt - V_START) : '0;

endmodule

// File: rtl/tvp_pattern_gen.sv
// Synthetic TVP source: registered HS/VS/luma with selectable test patterns.
// Define PATTERN_GEN_NOISE_EN to add LFSR noise on VIDEO[1:0] in active pixels.
module tvp_pattern_gen
  import hp2vga_pkg::*;
#(
  parameter int         H_TOTAL   = 1040,
  parameter int         H_SYNC    = 80,
  parameter int         H_BP      = 120,
  parameter int         H_ACTIVE  = 640,
  parameter int         V_TOTAL   = 400,
  parameter int         V_SYNC    = 3,
  parameter int         V_BP      = 20,
  parameter int         V_ACTIVE  = 368,
  parameter logic [9:0] LVL_BLANK = DEF_LVL_BLANK,
  parameter logic [9:0] LVL_BLACK = DEF_LVL_BLACK,
  parameter logic [9:0] LVL_WHITE = DEF_LVL_WHITE
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic [1:0] MODE,
  output logic       O_HS,
  output logic       O_VS,
  output logic [9:0] VIDEO,
  output logic       O_VISIBLE,
  output logic       FRAME_START
);

  logic       hsync_act;
  logic       vsync_act;
  logic       active;
  logic       origin;
  logic       frame_end;
  logic [9:0] x;
  logic [9:0] y;
  logic [7:0] frame_cnt;
  pattern_e   mode_q;
  logic [9:0] pixel;
  logic [9:0] shaded;
  logic       clear;
  logic       unused_bits;

  assign clear       = !RESET_N || !ENABLE;
  assign unused_bits = ^{y[9:4], y[2:0]};

  video_timing_gen #(
    .H_TOTAL (H_TOTAL),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .H_ACTIVE(H_ACTIVE),
    .V_TOTAL (V_TOTAL),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .V_ACTIVE(V_ACTIVE)
  ) u_timing (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .enable   (ENABLE),
    .hsync_act(hsync_act),
    .vsync_act(vsync_act),
    .active   (active),
    .origin   (origin),
    .frame_end(frame_end),
    .x        (x),
    .y        (y)
  );

  always_comb begin
    pixel = LVL_WHITE;
    case (mode_q)
      PAT_SOLID: pixel = LVL_WHITE;
      PAT_BARS:  pixel = x[3] ? LVL_BLACK : LVL_WHITE;
      PAT_CHECK: pixel = (x[3] ^ y[3]) ? LVL_BLACK : LVL_WHITE;
      PAT_RAMP:  pixel = ramp_value(x, frame_cnt);
      default:   pixel = LVL_WHITE;
    endcase
  end

`ifdef PATTERN_GEN_NOISE_EN
  logic [15:0] lfsr;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, free-running while enabled.
  always_ff @(posedge CLK) begin
    if (clear) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign shaded = {pixel[9:2], pixel[1:0] ^ lfsr[1:0]};
`else
  assign shaded = pixel;
`endif

  // Mode is latched at the frame origin so a frame never mixes patterns.
  always_ff @(posedge CLK) begin
    if (clear) begin
      O_HS        <= 1'b1;
      O_VS        <= 1'b1;
      VIDEO       <= LVL_BLANK;
      O_VISIBLE   <= 1'b0;
      FRAME_START <= 1'b0;
      frame_cnt   <= '0;
      mode_q      <= PAT_SOLID;
    end else begin
      O_HS        <= ~hsync_act;
      O_VS        <= ~vsync_act;
      VIDEO       <= active ? shaded : LVL_BLANK;
      O_VISIBLE   <= active;
      FRAME_START <= origin;
      if (origin) begin
        mode_q <= pattern_e'(MODE);
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule
